ps2_key_ctrl: RTL and testbench

//  Read-out sequencer for the ps2_keyboard scan-code FIFO. Pops one byte at a time using
//  the ready/nextdata_n handshake and parses make, break (F0) and extended (E0) prefixes.

---
 rtl/ps2_key_ctrl.sv | 241 ++++++++++++++++++++++++
 tb/tb_ps2_key_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_ctrl.sv
// ps2_key_ctrl: pops bytes from the ps2_keyboard scan-code FIFO one at a time,
// strips E0/F0 prefixes, emits one key event per complete code, and tracks
// modifier, capslock, typematic-repeat and fresh-press count state.
//
// FIFO handshake: when ready=1 in S_IDLE the head byte on data is taken on
// that clock edge and nextdata_n is driven low for exactly the following
// cycle. No further byte is taken until nextdata_n has returned high and
// GAP_CYCLES idle cycles have passed, so the FIFO head has settled.
module ps2_key_ctrl #(
  parameter int GAP_CYCLES = 1,
  parameter int COUNT_W    = 8
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               ready,
  input  logic [7:0]         data,
  input  logic               overflow,
  output logic               nextdata_n,
  output logic               key_valid,
  output logic [7:0]         key_code,
  output logic               key_ext,
  output logic               key_break,
  output logic               key_repeat,
  output logic               shift,
  output logic               ctrl,
  output logic               alt,
  output logic               capslock,
  output logic [COUNT_W-1:0] key_count,
  output logic [1:0]         err,
  output logic [1:0]         state_dbg
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_POP  = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  // {ext, code} identities of the modifier and lock keys
  localparam logic [8:0] ID_LSHIFT = 9'h012;
  localparam logic [8:0] ID_RSHIFT = 9'h059;
  localparam logic [8:0] ID_LCTRL  = 9'h014;
  localparam logic [8:0] ID_RCTRL  = 9'h114;
  localparam logic [8:0] ID_LALT   = 9'h011;
  localparam logic [8:0] ID_RALT   = 9'h111;
  localparam logic [8:0] ID_CAPS   = 9'h058;

  logic [1:0]         state_q, state_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic               nextdata_n_q, nextdata_n_d;
  logic               ext_q, ext_d, brk_q, brk_d;
  logic               key_valid_q, key_valid_d;
  logic [7:0]         key_code_q, key_code_d;
  logic               key_ext_q, key_ext_d;
  logic               key_break_q, key_break_d;
  logic               key_repeat_q, key_repeat_d;
  logic               last_valid_q, last_valid_d;
  logic               last_ext_q, last_ext_d;
  logic [7:0]         last_code_q, last_code_d;
  logic               lshift_q, lshift_d, rshift_q, rshift_d;
  logic               lctrl_q, lctrl_d, rctrl_q, rctrl_d;
  logic               lalt_q, lalt_d, ralt_q, ralt_d;
  logic               capslock_q, capslock_d;
  logic [COUNT_W-1:0] key_count_q, key_count_d;
  logic [1:0]         err_q, err_d;

  // Classification of the byte currently at the FIFO head
  logic [8:0] key_id;
  logic       is_same, is_mod, is_caps;
  assign key_id  = {ext_q, data};
  assign is_same = last_valid_q && (last_ext_q == ext_q) && (last_code_q == data);
  assign is_caps = (key_id == ID_CAPS);
  assign is_mod  = (key_id == ID_LSHIFT) || (key_id == ID_RSHIFT) ||
                   (key_id == ID_LCTRL)  || (key_id == ID_RCTRL)  ||
                   (key_id == ID_LALT)   || (key_id == ID_RALT);

  // Sequencer FSM and byte decode; decode happens on the edge that takes the byte
  always_comb begin
    state_d      = state_q;
    gap_cnt_d    = gap_cnt_q;
    nextdata_n_d = 1'b1;
    ext_d        = ext_q;
    brk_d        = brk_q;
    key_valid_d  = 1'b0;
    key_code_d   = key_code_q;
    key_ext_d    = key_ext_q;
    key_break_d  = key_break_q;
    key_repeat_d = key_repeat_q;
    last_valid_d = last_valid_q;
    last_ext_d   = last_ext_q;
    last_code_d  = last_code_q;
    lshift_d     = lshift_q;
    rshift_d     = rshift_q;
    lctrl_d      = lctrl_q;
    rctrl_d      = rctrl_q;
    lalt_d       = lalt_q;
    ralt_d       = ralt_q;
    capslock_d   = capslock_q;
    key_count_d  = key_count_q;
    err_d        = {err_q[1] | overflow, err_q[0]};

    case (state_q)
      S_IDLE: begin
        if (ready) begin
          nextdata_n_d = 1'b0;
          state_d      = S_POP;
          if (data == 8'hE0) begin
            if (ext_q || brk_q) begin
              err_d[0] = 1'b1;
              ext_d    = 1'b0;
              brk_d    = 1'b0;
            end else begin
              ext_d = 1'b1;
            end
          end else if (data == 8'hF0) begin
            if (brk_q) begin
              err_d[0] = 1'b1;
              ext_d    = 1'b0;
              brk_d    = 1'b0;
            end else begin
              brk_d = 1'b1;
            end
          end else if ((data == 8'h00) || (data == 8'hFF)) begin
            err_d[0] = 1'b1;
            ext_d    = 1'b0;
            brk_d    = 1'b0;
          end else if ((data == 8'hAA) && !ext_q && !brk_q) begin
            // BAT completion code: nothing to report
          end else begin
            key_valid_d = 1'b1;
            key_code_d  = data;
            key_ext_d   = ext_q;
            key_break_d = brk_q;
            ext_d       = 1'b0;
            brk_d       = 1'b0;
            if (brk_q) begin
              key_repeat_d = 1'b0;
              if (is_same) last_valid_d = 1'b0;
            end else begin
              key_repeat_d = is_same;
              if (!is_same) begin
                last_valid_d = 1'b1;
                last_ext_d   = ext_q;
                last_code_d  = data;
                if (is_caps) capslock_d = ~capslock_q;
                if (!is_caps && !is_mod) key_count_d = key_count_q + 1'b1;
              end
            end
            // Each modifier side follows make (set) / break (clear)
            if (key_id == ID_LSHIFT) lshift_d = ~brk_q;
            if (key_id == ID_RSHIFT) rshift_d = ~brk_q;
            if (key_id == ID_LCTRL)  lctrl_d  = ~brk_q;
            if (key_id == ID_RCTRL)  rctrl_d  = ~brk_q;
            if (key_id == ID_LALT)   lalt_d   = ~brk_q;
            if (key_id == ID_RALT)   ralt_d   = ~brk_q;
          end
        end
      end
      S_POP: begin
        state_d   = S_GAP;
        gap_cnt_d = '0;
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d   = S_IDLE;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; clr wins over everything, including a pop in flight
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q      <= S_IDLE;
      gap_cnt_q    <= '0;
      nextdata_n_q <= 1'b1;
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      key_valid_q  <= 1'b0;
      key_code_q   <= 8'h00;
      key_ext_q    <= 1'b0;
      key_break_q  <= 1'b0;
      key_repeat_q <= 1'b0;
      last_valid_q <= 1'b0;
      last_ext_q   <= 1'b0;
      last_code_q  <= 8'h00;
      lshift_q     <= 1'b0;
      rshift_q     <= 1'b0;
      lctrl_q      <= 1'b0;
      rctrl_q      <= 1'b0;
      lalt_q       <= 1'b0;
      ralt_q       <= 1'b0;
      capslock_q   <= 1'b0;
      key_count_q  <= '0;
      err_q        <= 2'b00;
    end else begin
      state_q      <= state_d;
      gap_cnt_q    <= gap_cnt_d;
      nextdata_n_q <= nextdata_n_d;
      ext_q        <= ext_d;
      brk_q        <= brk_d;
      key_valid_q  <= key_valid_d;
      key_code_q   <= key_code_d;
      key_ext_q    <= key_ext_d;
      key_break_q  <= key_break_d;
      key_repeat_q <= key_repeat_d;
      last_valid_q <= last_valid_d;
      last_ext_q   <= last_ext_d;
      last_code_q  <= last_code_d;
      lshift_q     <= lshift_d;
      rshift_q     <= rshift_d;
      lctrl_q      <= lctrl_d;
      rctrl_q      <= rctrl_d;
      lalt_q       <= lalt_d;
      ralt_q       <= ralt_d;
      capslock_q   <= capslock_d;
      key_count_q  <= key_count_d;
      err_q        <= err_d;
    end
  end

  assign nextdata_n = nextdata_n_q;
  assign key_valid  = key_valid_q;
  assign key_code   = key_code_q;
  assign key_ext    = key_ext_q;
  assign key_break  = key_break_q;
  assign key_repeat = key_repeat_q;
  assign shift      = lshift_q | rshift_q;
  assign ctrl       = lctrl_q | rctrl_q;
  assign alt        = lalt_q | ralt_q;
  assign capslock   = capslock_q;
  assign key_count  = key_count_q;
  assign err        = err_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Table-driven bench for ps2_key_ctrl: a vector table of bytes with
// hand-computed expected outputs, then hand-written multi-cycle sequences
// (error recovery, overflow stickiness, clr during a pop).
module tb_ps2_key_ctrl;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data = 8'h00;
  logic       overflow = 1'b0;
  logic       nextdata_n, key_valid, key_ext, key_break, key_repeat;
  logic       shift, ctrl, alt, capslock;
  logic [7:0] key_code, key_count;
  logic [1:0] err, state_dbg;

  int total = 0;
  int bad = 0;
  int pops = 0;

  typedef struct {
    logic [7:0] d;
    logic       v;
    logic [7:0] code;
    logic       e, b, r, sh, ct, al, cp;
    logic [7:0] cnt;
    logic [1:0] err;
  } vec_t;

  vec_t vq[$];

  ps2_key_ctrl #(.GAP_CYCLES(1), .COUNT_W(8)) dut (
    .clk(clk), .clr(clr), .ready(ready), .data(data), .overflow(overflow),
    .nextdata_n(nextdata_n), .key_valid(key_valid), .key_code(key_code),
    .key_ext(key_ext), .key_break(key_break), .key_repeat(key_repeat),
    .shift(shift), .ctrl(ctrl), .alt(alt), .capslock(capslock),
    .key_count(key_count), .err(err), .state_dbg(state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  // Count cycles with the pop strobe low
  always @(posedge clk) if (!nextdata_n && !clr) pops <= pops + 1;

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, act=running exp=done");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [7:0] d, input logic v, input logic [7:0] code,
                     input logic e, input logic b, input logic r, input logic sh,
                     input logic ct, input logic al, input logic cp,
                     input logic [7:0] cnt, input logic [1:0] er);
    vec_t x;
    x.d = d; x.v = v; x.code = code; x.e = e; x.b = b; x.r = r;
    x.sh = sh; x.ct = ct; x.al = al; x.cp = cp; x.cnt = cnt; x.err = er;
    vq.push_back(x);
  endtask

  // Offer one byte and wait (bounded) for the cycle in which it is popped;
  // returns with sampling point #1 after the edge that took the byte.
  task automatic send(input logic [7:0] b, input string name);
    bit got = 0;
    @(negedge clk);
    ready = 1'b1;
    data  = b;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (!nextdata_n) begin
        got = 1;
        break;
      end
    end
    ready = 1'b0;
    total++;
    if (!got) begin
      bad++;
      $display("FAIL %s pop timeout: act=no_pop exp=pop", name);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr = 1'b1;
    ready = 1'b0;
    overflow = 1'b0;
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    // {data, v, code, ext, brk, rep, shift, ctrl, alt, caps, count, err}
    add(8'h1C, 1, 8'h1C, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00);  // 0 plain make
    add(8'hF0, 0, 8'h1C, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00);
    add(8'h1C, 1, 8'h1C, 0, 1, 0, 0, 0, 0, 0, 1, 2'b00);  // 2 break
    add(8'hE0, 0, 8'h1C, 0, 1, 0, 0, 0, 0, 0, 1, 2'b00);
    add(8'h14, 1, 8'h14, 1, 0, 0, 0, 1, 0, 0, 1, 2'b00);  // 4 R-ctrl make
    add(8'hE0, 0, 8'h14, 1, 0, 0, 0, 1, 0, 0, 1, 2'b00);
    add(8'hF0, 0, 8'h14, 1, 0, 0, 0, 1, 0, 0, 1, 2'b00);
    add(8'h14, 1, 8'h14, 1, 1, 0, 0, 0, 0, 0, 1, 2'b00);  // 7 R-ctrl break
    add(8'h58, 1, 8'h58, 0, 0, 0, 0, 0, 0, 1, 1, 2'b00);  // 8 caps on
    add(8'h58, 1, 8'h58, 0, 0, 1, 0, 0, 0, 1, 1, 2'b00);  // 9 repeat
    add(8'h58, 1, 8'h58, 0, 0, 1, 0, 0, 0, 1, 1, 2'b00);
    add(8'hF0, 0, 8'h58, 0, 0, 1, 0, 0, 0, 1, 1, 2'b00);
    add(8'h58, 1, 8'h58, 0, 1, 0, 0, 0, 0, 1, 1, 2'b00);  // 12 caps break
    add(8'h58, 1, 8'h58, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00);  // 13 caps off
    add(8'hF0, 0, 8'h58, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00);
    add(8'h58, 1, 8'h58, 0, 1, 0, 0, 0, 0, 0, 1, 2'b00);
    add(8'h12, 1, 8'h12, 0, 0, 0, 1, 0, 0, 0, 1, 2'b00);  // 16 L-shift
    add(8'h59, 1, 8'h59, 0, 0, 0, 1, 0, 0, 0, 1, 2'b00);  // 17 R-shift
    add(8'hF0, 0, 8'h59, 0, 0, 0, 1, 0, 0, 0, 1, 2'b00);
    add(8'h12, 1, 8'h12, 0, 1, 0, 1, 0, 0, 0, 1, 2'b00);  // 19 shift held by R
    add(8'hF0, 0, 8'h12, 0, 1, 0, 1, 0, 0, 0, 1, 2'b00);
    add(8'h59, 1, 8'h59, 0, 1, 0, 0, 0, 0, 0, 1, 2'b00);  // 21 shift off
    add(8'h11, 1, 8'h11, 0, 0, 0, 0, 0, 1, 0, 1, 2'b00);  // 22 L-alt
    add(8'hF0, 0, 8'h11, 0, 0, 0, 0, 0, 1, 0, 1, 2'b00);
    add(8'h11, 1, 8'h11, 0, 1, 0, 0, 0, 0, 0, 1, 2'b00);
    add(8'hAA, 0, 8'h11, 0, 1, 0, 0, 0, 0, 0, 1, 2'b00);  // 25 BAT dropped
    add(8'h00, 0, 8'h11, 0, 1, 0, 0, 0, 0, 0, 1, 2'b01);  // 26 kbd error
    add(8'h2A, 1, 8'h2A, 0, 0, 0, 0, 0, 0, 0, 2, 2'b01);  // 27 draining continues
    add(8'h2A, 1, 8'h2A, 0, 0, 1, 0, 0, 0, 0, 2, 2'b01);  // 28 repeat, no count
    add(8'hE0, 0, 8'h2A, 0, 0, 1, 0, 0, 0, 0, 2, 2'b01);
    add(8'h2A, 1, 8'h2A, 1, 0, 0, 0, 0, 0, 0, 3, 2'b01);  // 30 E0 2A is a new key
    add(8'hE0, 0, 8'h2A, 1, 0, 0, 0, 0, 0, 0, 3, 2'b01);
    add(8'hE0, 0, 8'h2A, 1, 0, 0, 0, 0, 0, 0, 3, 2'b01);  // 32 double E0 error
    add(8'hF0, 0, 8'h2A, 1, 0, 0, 0, 0, 0, 0, 3, 2'b01);
    add(8'hAA, 1, 8'hAA, 0, 1, 0, 0, 0, 0, 0, 3, 2'b01);  // 34 F0 AA is a break

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset nextdata_n", nextdata_n, 1);
    chk("reset key_valid", key_valid, 0);
    chk("reset key_code", key_code, 0);
    chk("reset mods", {shift, ctrl, alt, capslock, key_repeat, key_ext, key_break}, 0);
    chk("reset key_count", key_count, 0);
    chk("reset err", err, 0);
    @(negedge clk);
    clr = 1'b0;

    // Vector table
    foreach (vq[i]) begin
      send(vq[i].d, $sformatf("row%0d", i));
      chk($sformatf("row%0d key_valid", i), key_valid, vq[i].v);
      chk($sformatf("row%0d key_code", i), key_code, vq[i].code);
      chk($sformatf("row%0d ext/brk/rep", i), {key_ext, key_break, key_repeat},
          {vq[i].e, vq[i].b, vq[i].r});
      chk($sformatf("row%0d sh/ct/al/cp", i), {shift, ctrl, alt, capslock},
          {vq[i].sh, vq[i].ct, vq[i].al, vq[i].cp});
      chk($sformatf("row%0d key_count", i), key_count, vq[i].cnt);
      chk($sformatf("row%0d err", i), err, vq[i].err);
    end
    @(posedge clk);
    #1;
    chk("strobe one cycle", key_valid, 0);
    chk("pop strobe one cycle", nextdata_n, 1);
    chk("pop count", pops, vq.size());

    // F0 F0 error, then recovery with a normal make
    do_reset();
    send(8'hF0, "dbl_f0 a");
    send(8'hF0, "dbl_f0 b");
    chk("dbl_f0 err", err, 2'b01);
    chk("dbl_f0 no event", key_valid, 0);
    send(8'h1C, "recover");
    chk("recover valid", key_valid, 1);
    chk("recover code/brk", {key_code, key_break, key_ext}, {8'h1C, 2'b00});
    chk("recover count", key_count, 1);

    // Overflow pulse sets sticky err[1]
    @(negedge clk);
    overflow = 1'b1;
    @(negedge clk);
    overflow = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("overflow sticky", err, 2'b11);
    do_reset();
    #1;
    chk("err cleared by clr", err, 2'b00);

    // clr during S_POP with ready held high
    @(negedge clk);
    ready = 1'b1;
    data  = 8'h1C;
    @(posedge clk);
    #1;
    chk("mid-pop strobe low", nextdata_n, 0);
    chk("mid-pop state", state_dbg, 2'd1);
    clr = 1'b1;
    #1;
    chk("clr mid-pop nextdata_n", nextdata_n, 1);
    chk("clr mid-pop key_valid", key_valid, 0);
    chk("clr mid-pop outputs", {key_code, key_count, err}, 0);
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    @(posedge clk);
    #1;
    chk("post-clr pop latency", nextdata_n, 0);
    chk("post-clr event", {key_valid, key_code}, {1'b1, 8'h1C});
    chk("post-clr count", key_count, 1);
    ready = 1'b0;
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
